// File: rtl/cond_unit_e.sv
// Execute-stage condition unit: ARM NZCV flags, condition/branch evaluation,
// write-enable gating and the E/M pipeline register.
module cond_unit_e #(
  parameter int XLEN = 32,
  parameter int RW   = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ValidE,
  input  logic            KillE,
  input  logic            StallM,
  input  logic            FlushM,
  input  logic            ArmE,
  input  logic [3:0]      CondE,
  input  logic [1:0]      FlagWriteE,
  input  logic            BranchE,
  input  logic            BranchNegE,
  input  logic            RegWriteE,
  input  logic            MemWriteE,
  input  logic [XLEN-1:0] ALUResultE,
  input  logic [3:0]      ALUFlags,
  input  logic            ZeroE,
  input  logic [XLEN-1:0] WriteDataE,
  input  logic [RW-1:0]   RdE,
  output logic            CondExE,
  output logic            PCSrcE,
  output logic [3:0]      FlagsQ,
  output logic            ValidM,
  output logic            RegWriteM,
  output logic            MemWriteM,
  output logic [XLEN-1:0] ALUResultM,
  output logic [XLEN-1:0] WriteDataM,
  output logic [RW-1:0]   RdM
);

  logic flag_n, flag_z, flag_c, flag_v;
  logic cond_pass;
  logic live;
  logic taken;
  logic flag_en;

  assign {flag_n, flag_z, flag_c, flag_v} = FlagsQ;

  // Conditions look only at the registered flags; there is no forwarding path.
  always_comb begin
    cond_pass = 1'b1;
    case (CondE)
      4'b0000: cond_pass = flag_z;
      4'b0001: cond_pass = !flag_z;
      4'b0010: cond_pass = flag_c;
      4'b0011: cond_pass = !flag_c;
      4'b0100: cond_pass = flag_n;
      4'b0101: cond_pass = !flag_n;
      4'b0110: cond_pass = flag_v;
      4'b0111: cond_pass = !flag_v;
      4'b1000: cond_pass = flag_c & !flag_z;
      4'b1001: cond_pass = !flag_c | flag_z;
      4'b1010: cond_pass = (flag_n == flag_v);
      4'b1011: cond_pass = (flag_n != flag_v);
      4'b1100: cond_pass = !flag_z & (flag_n == flag_v);
      4'b1101: cond_pass = flag_z | (flag_n != flag_v);
      default: cond_pass = 1'b1;
    endcase
  end

  assign CondExE = ArmE ? cond_pass : 1'b1;
  assign live    = ValidE & !KillE;
  assign taken   = ArmE ? CondExE : (BranchNegE ? !ZeroE : ZeroE);
  assign PCSrcE  = live & BranchE & taken;
  assign flag_en = live & ArmE & CondExE & !StallM;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      FlagsQ <= 4'b0000;
    end else if (flag_en) begin
      if (FlagWriteE[1]) FlagsQ[3:2] <= ALUFlags[3:2];
      if (FlagWriteE[0]) FlagsQ[1:0] <= ALUFlags[1:0];
    end
  end

  // Flush wins over stall; a flushed slot keeps its stale data fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ValidM     <= 1'b0;
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ALUResultM <= '0;
      WriteDataM <= '0;
      RdM        <= '0;
    end else if (FlushM) begin
      ValidM    <= 1'b0;
      RegWriteM <= 1'b0;
      MemWriteM <= 1'b0;
    end else if (!StallM) begin
      ValidM     <= live;
      RegWriteM  <= RegWriteE & CondExE & live;
      MemWriteM  <= MemWriteE & CondExE & live;
      ALUResultM <= ALUResultE;
      WriteDataM <= WriteDataE;
      RdM        <= RdE;
    end
  end

endmodule

// File: tb/tb_cond_unit_e.sv
// Self-checking bench for cond_unit_e: directed test-plan scenarios plus
// randomized traffic against a behavioural model of the flags and M stage.
module tb_cond_unit_e;

  localparam int XLEN = 32;
  localparam int RW   = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            ValidE, KillE, StallM, FlushM, ArmE;
  logic [3:0]      CondE;
  logic [1:0]      FlagWriteE;
  logic            BranchE, BranchNegE, RegWriteE, MemWriteE;
  logic [XLEN-1:0] ALUResultE;
  logic [3:0]      ALUFlags;
  logic            ZeroE;
  logic [XLEN-1:0] WriteDataE;
  logic [RW-1:0]   RdE;
  logic            CondExE, PCSrcE;
  logic [3:0]      FlagsQ;
  logic            ValidM, RegWriteM, MemWriteM;
  logic [XLEN-1:0] ALUResultM, WriteDataM;
  logic [RW-1:0]   RdM;

  int checks = 0;
  int errors = 0;

  // model state
  bit [3:0]      m_flags;
  bit            m_valid, m_rw, m_mw;
  bit [XLEN-1:0] m_res, m_wd;
  bit [RW-1:0]   m_rd;

  always #5 clk = ~clk;

  cond_unit_e #(.XLEN(XLEN), .RW(RW)) dut (
    .clk(clk), .rst_n(rst_n), .ValidE(ValidE), .KillE(KillE), .StallM(StallM),
    .FlushM(FlushM), .ArmE(ArmE), .CondE(CondE), .FlagWriteE(FlagWriteE),
    .BranchE(BranchE), .BranchNegE(BranchNegE), .RegWriteE(RegWriteE),
    .MemWriteE(MemWriteE), .ALUResultE(ALUResultE), .ALUFlags(ALUFlags),
    .ZeroE(ZeroE), .WriteDataE(WriteDataE), .RdE(RdE), .CondExE(CondExE),
    .PCSrcE(PCSrcE), .FlagsQ(FlagsQ), .ValidM(ValidM), .RegWriteM(RegWriteM),
    .MemWriteM(MemWriteM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .RdM(RdM)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit cond_ref(input bit [3:0] code, input bit [3:0] f);
    bit n, z, c, v;
    {n, z, c, v} = f;
    case (code)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return c;
      4'd3:  return !c;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return c && !z;
      4'd9:  return !c || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  task automatic idle();
    ValidE = 0; KillE = 0; StallM = 0; FlushM = 0; ArmE = 1; CondE = 4'hE;
    FlagWriteE = 0; BranchE = 0; BranchNegE = 0; RegWriteE = 0; MemWriteE = 0;
    ALUResultE = 0; ALUFlags = 0; ZeroE = 0; WriteDataE = 0; RdE = 0;
  endtask

  task automatic model_reset();
    m_flags = 0; m_valid = 0; m_rw = 0; m_mw = 0; m_res = 0; m_wd = 0; m_rd = 0;
  endtask

  task automatic check_m();
    chk("flags", FlagsQ, m_flags);
    chk("valid_m", ValidM, m_valid);
    chk("regwrite_m", RegWriteM, m_rw);
    chk("memwrite_m", MemWriteM, m_mw);
    chk("result_m", ALUResultM, m_res);
    chk("wdata_m", WriteDataM, m_wd);
    chk("rd_m", RdM, m_rd);
  endtask

  // Entered at a falling edge with inputs applied; returns at the next falling edge.
  task automatic step();
    bit c, live, tk;
    #1;
    c    = ArmE ? cond_ref(CondE, m_flags) : 1'b1;
    live = ValidE && !KillE;
    tk   = ArmE ? c : (BranchNegE ? !ZeroE : ZeroE);
    chk("cond_ex", CondExE, c);
    chk("pcsrc", PCSrcE, live && BranchE && tk);
    if (live && ArmE && c && !StallM) begin
      if (FlagWriteE[1]) m_flags[3:2] = ALUFlags[3:2];
      if (FlagWriteE[0]) m_flags[1:0] = ALUFlags[1:0];
    end
    if (FlushM) begin
      m_valid = 0; m_rw = 0; m_mw = 0;
    end else if (!StallM) begin
      m_valid = live;
      m_rw    = RegWriteE && c && live;
      m_mw    = MemWriteE && c && live;
      m_res   = ALUResultE;
      m_wd    = WriteDataE;
      m_rd    = RdE;
    end
    @(posedge clk);
    @(negedge clk);
    check_m();
  endtask

  task automatic set_flags(input bit [3:0] f);
    idle(); ValidE = 1; ArmE = 1; CondE = 4'hE; FlagWriteE = 2'b11; ALUFlags = f;
    step();
  endtask

  initial begin
    bit [3:0] held_flags;
    idle();
    model_reset();
    rst_n = 0;
    #12;
    check_m();
    @(negedge clk);
    rst_n = 1;

    // flag set then use
    idle(); ValidE = 1; ArmE = 1; FlagWriteE = 2'b11; ALUFlags = 4'b0100;
    step();
    chk("subs_flags", FlagsQ, 4'b0100);
    idle(); ValidE = 1; ArmE = 1; CondE = 4'b0000; BranchE = 1;
    #1;
    chk("eq_cond", CondExE, 1'b1);
    chk("eq_branch", PCSrcE, 1'b1);
    step();

    // failed condition (Z=1, NE)
    idle(); ValidE = 1; ArmE = 1; CondE = 4'b0001; RegWriteE = 1; MemWriteE = 1;
    ALUResultE = 32'h1234;
    step();
    chk("fail_valid", ValidM, 1'b1);
    chk("fail_rw", RegWriteM, 1'b0);
    chk("fail_mw", MemWriteM, 1'b0);
    chk("fail_res", ALUResultM, 32'h1234);

    // RISC-V branch never touches flags
    idle(); ValidE = 1; ArmE = 0; BranchE = 1; BranchNegE = 1; ZeroE = 0;
    FlagWriteE = 2'b11; ALUFlags = 4'b1010;
    #1;
    chk("rv_bne_taken", PCSrcE, 1'b1);
    step();
    chk("rv_flags_hold", FlagsQ, 4'b0100);
    KillE = 1;
    #1;
    chk("rv_killed", PCSrcE, 1'b0);
    step();

    // partial flag write
    set_flags(4'b1111);
    idle(); ValidE = 1; ArmE = 1; FlagWriteE = 2'b10; ALUFlags = 4'b0000;
    step();
    chk("partial_flags", FlagsQ, 4'b0011);

    // condition sweep
    for (int f = 0; f < 16; f++) begin
      set_flags(f[3:0]);
      for (int cc = 0; cc < 16; cc++) begin
        idle(); ArmE = 1; CondE = cc[3:0];
        #1;
        chk($sformatf("sweep_f%0h_c%0h", f, cc), CondExE, cond_ref(cc[3:0], f[3:0]));
        if (f == 9 && cc == 12) chk("gt_1001", CondExE, 1'b1);
        if (f == 8 && cc == 13) chk("le_1000", CondExE, 1'b1);
      end
    end
    step();

    // stall two cycles with flag writes pending
    idle(); ValidE = 1; ArmE = 1; RegWriteE = 1; ALUResultE = 32'hCAFE; RdE = 5'd7;
    FlagWriteE = 2'b11; ALUFlags = 4'b0110;
    step();
    held_flags = m_flags;
    for (int i = 0; i < 2; i++) begin
      idle(); ValidE = 1; ArmE = 1; StallM = 1; FlagWriteE = 2'b11; ALUFlags = ~held_flags;
      ALUResultE = 32'hBEEF; RdE = 5'd3;
      step();
      chk("stall_flags", FlagsQ, held_flags);
      chk("stall_res", ALUResultM, 32'hCAFE);
    end
    idle(); ValidE = 1; StallM = 1; FlushM = 1;
    step();
    chk("stall_flush_valid", ValidM, 1'b0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      ValidE     = ($urandom_range(0, 7) != 0);
      KillE      = ($urandom_range(0, 7) == 0);
      StallM     = ($urandom_range(0, 7) == 0);
      FlushM     = ($urandom_range(0, 9) == 0);
      ArmE       = $urandom_range(0, 1);
      CondE      = $urandom_range(0, 15);
      FlagWriteE = $urandom_range(0, 3);
      BranchE    = $urandom_range(0, 1);
      BranchNegE = $urandom_range(0, 1);
      RegWriteE  = $urandom_range(0, 1);
      MemWriteE  = $urandom_range(0, 1);
      ALUResultE = $urandom;
      ALUFlags   = $urandom_range(0, 15);
      ZeroE      = $urandom_range(0, 1);
      WriteDataE = $urandom;
      RdE        = $urandom_range(0, 31);
      step();
    end

    // asynchronous reset mid-cycle, during a stall
    set_flags(4'b1011);
    idle(); ValidE = 1; RegWriteE = 1; MemWriteE = 1; ALUResultE = 32'h55; WriteDataE = 32'h66;
    RdE = 5'd9;
    step();
    idle(); StallM = 1;
    #2;
    rst_n = 0;
    model_reset();
    #1;
    check_m();
    @(negedge clk);
    rst_n = 1;
    idle();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cond_unit_e.md
Name: cond_unit_e

Overview:
- Execute-stage condition unit and E/M pipeline register; directly consumes the ALU outputs (ALUResultE, ALUFlags, ZeroE).
- Holds the architectural ARM NZCV flags register and evaluates ARM condition codes and RISC-V branch outcomes.
- Gates the write-enables of each instruction and registers the result into the Memory stage.
- Provides the branch-taken redirect (PCSrcE) to fetch.

Parameters:
- XLEN, 32, datapath width of result and store data.
- RW, 5, register-index width; ARM uses the low 4 bits, the top bit is 0.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ValidE  in  1  E holds a real instruction.
- KillE  in  1  instruction in E is squashed; it has no architectural effect.
- StallM  in  1  hold the E/M register and flags.
- FlushM  in  1  insert a bubble into M.
- ArmE  in  1  1 = ARM instruction, 0 = RISC-V.
- CondE  in  4  ARM condition field.
- FlagWriteE  in  2  [1] writes N,Z; [0] writes C,V.
- BranchE  in  1  branch instruction.
- BranchNegE  in  1  RISC-V only: take the branch when ZeroE=0 (bne/blt/bltu); otherwise take when ZeroE=1.
- RegWriteE, MemWriteE  in  1 each  ungated enables.
- ALUResultE  in  XLEN  from the ALU.
- ALUFlags  in  4  {N,Z,C,V} from the ALU.
- ZeroE  in  1  from the ALU.
- WriteDataE  in  XLEN  store data.
- RdE  in  RW  destination register.
- CondExE  out  1  condition passed (combinational).
- PCSrcE  out  1  branch taken (combinational).
- FlagsQ  out  4  current registered {N,Z,C,V}.
- ValidM, RegWriteM, MemWriteM  out  1 each  registered, gated.
- ALUResultM, WriteDataM  out  XLEN  registered.
- RdM  out  RW  registered.

Behaviour:
- Reset (rst_n=0, asynchronous): FlagsQ=0000, and ValidM, RegWriteM, MemWriteM, ALUResultM, WriteDataM and RdM are all 0.
- Condition evaluation uses the registered FlagsQ; no flag forwarding exists.
  - Codes: 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V; 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 treated as 1.
  - When ArmE=0, CondExE=1.
- Live = ValidE & !KillE.
- PCSrcE = Live & BranchE & taken.
  - ARM: taken = CondExE.
  - RISC-V: taken = BranchNegE ? !ZeroE : ZeroE.
- Flags update at the clock edge when Live & ArmE & CondExE & !StallM:
  - N,Z load from ALUFlags[3:2] if FlagWriteE[1].
  - C,V load from ALUFlags[1:0] if FlagWriteE[0].
  - Bits not selected hold their value.
  - Latency is one cycle: the next instruction in E sees the new flags.
- E/M register, priority order at each edge:
  1. FlushM: ValidM, RegWriteM and MemWriteM go to 0; data fields are don't-care and are held. FlushM overrides StallM.
  2. StallM: all M outputs hold.
  3. Otherwise: ValidM=Live, RegWriteM=RegWriteE&CondExE&Live, MemWriteM=MemWriteE&CondExE&Live; ALUResultM, WriteDataM and RdM capture their E values.
- KillE with StallM: flags are not updated and M holds.
- A failed ARM condition still advances ValidM=1, with both enables 0.
- A RISC-V instruction never touches FlagsQ.
- Reset asserted mid-stall clears everything immediately; there is no pending state.

Test Plan:
- Flag set then use:
  - Cycle 1: ARM subs, ALUFlags=0100, FlagWriteE=11.
  - Cycle 2: CondE=0000, BranchE=1.
  - Required: FlagsQ=0100 after the edge, and CondExE=1 and PCSrcE=1 in cycle 2.
- Partial flag write:
  - Setup: FlagsQ=1111.
  - Stimulus: FlagWriteE=10 with ALUFlags=0000.
  - Required: FlagsQ=0011.
- Condition sweep:
  - Stimulus: all 16 CondE values against all 16 FlagsQ patterns.
  - Required: CondExE matches the table above.
  - Required: GT with FlagsQ=1001 gives 1; LE with FlagsQ=1000 gives 1.
- Failed condition:
  - Stimulus: ARM CondE=0001, FlagsQ Z=1, RegWriteE=1, MemWriteE=1, ALUResultE=32'h1234.
  - Required: ValidM=1, RegWriteM=0, MemWriteM=0, ALUResultM=32'h1234.
- RISC-V branch:
  - Stimulus: ArmE=0, BranchE=1, BranchNegE=1, ZeroE=0.
  - Required: PCSrcE=1 and FlagsQ unchanged.
  - With KillE=1 instead: PCSrcE=0.
- Stall, flush and reset:
  - StallM=1 for 2 cycles with FlagWriteE=11: M outputs and FlagsQ hold.
  - StallM=1 together with FlushM=1: ValidM goes to 0.
  - rst_n low mid-cycle: all outputs go to 0 without waiting for a clock edge.
